// File: rtl/registro_pipeline.sv
// rtl/registro_pipeline.sv - DEPTH-stage handshaked register pipeline with bubble collapse
// Each stage advances whenever some stage downstream of it can make room.
module registro_pipeline #(
    parameter int n     = 6,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       CE,
    input  logic                       FLUSH,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [n-1:0]               DATA_IN,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [n-1:0]               DATA_OUT,
    output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [n-1:0]     data_q [DEPTH];
    logic [OW-1:0]    occ_q;

    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] src_valid;
    logic [n-1:0]     src_data [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // A stage can accept a word if the consumer is ready or any stage from here to the end is empty.
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            assign free[g] = OUT_READY | ~(&valid_q[DEPTH-1:g]);
            if (g == 0) begin : g_head
                assign src_valid[g] = in_fire;
                assign src_data[g]  = DATA_IN;
            end else begin : g_body
                assign src_valid[g] = valid_q[g-1];
                assign src_data[g]  = data_q[g-1];
            end
        end
    endgenerate

    assign IN_READY  = RESET_N & CE & ~FLUSH & free[0];
    assign in_fire   = IN_VALID & IN_READY;
    assign OUT_VALID = valid_q[DEPTH-1];
    assign DATA_OUT  = data_q[DEPTH-1];
    assign out_fire  = OUT_VALID & OUT_READY;
    assign OCCUPANCY = occ_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (FLUSH) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else if (CE) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (free[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= src_data[k];
                    end
                end
            end
        end else if (out_fire) begin
            // Stalled: the consumer may still take the head word, nothing else moves.
            valid_q[DEPTH-1] <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            occ_q <= '0;
        end else if (FLUSH) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OW'(in_fire) - OW'(out_fire);
        end
    end

endmodule

// File: tb/tb_registro_pipeline.sv
// tb/tb_registro_pipeline.sv - scoreboard bench for registro_pipeline (n=6, DEPTH=4)
module tb_registro_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] data_in;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] data_out;
    logic [2:0] occupancy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] exp_q [$];

    registro_pipeline #(.n(6), .DEPTH(4)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .CE        (ce),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .DATA_IN   (data_in),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .DATA_OUT  (data_out),
        .OCCUPANCY (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; accepted words are pushed to the scoreboard.
    task automatic cyc(input logic iv, input logic [5:0] din, input logic ordy,
                       input logic c, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        data_in   = din;
        out_ready = ordy;
        ce        = c;
        flush     = fl;
        #2;
        if (in_valid && in_ready) exp_q.push_back(din);
        if (fl) begin
            @(posedge clk);
            #1;
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", data_out);
            end else begin
                chk("data_out_order", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; ce = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            data_in   = 6'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            ce        = 1'b1;
            #2;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_data_out", data_out, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("rel_in_ready", in_ready, 1);

        // latency and throughput
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 6'(i + 1), 1'b1, 1'b1, 1'b0);
            chk("t2_in_ready", in_ready, 1);
            chk("t2_out_valid", out_valid, (i >= 4) ? 1 : 0);
            chk("t2_occupancy", occupancy, (i < 4) ? i : 4);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t2_drained_occ", occupancy, 0);
        chk("t2_drained_q", exp_q.size(), 0);

        // backpressure and full pipeline
        cyc(1'b1, 6'h11, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h22, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h33, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h24, 1'b0, 1'b1, 1'b0);
        chk("t3_ready_before_full", in_ready, 1);
        cyc(1'b1, 6'h3c, 1'b0, 1'b1, 1'b0);
        chk("t3_full_in_ready", in_ready, 0);
        chk("t3_full_occ", occupancy, 4);
        chk("t3_full_out_valid", out_valid, 1);
        chk("t3_full_data", data_out, 6'h11);
        cyc(1'b1, 6'h3c, 1'b0, 1'b1, 1'b0);
        chk("t3_stable_data", data_out, 6'h11);
        chk("t3_no_capture", exp_q.size(), 4);
        cyc(1'b1, 6'h3c, 1'b1, 1'b1, 1'b0);
        chk("t3_full_ready_passthru", in_ready, 1);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        chk("t3_occ_after_swap", occupancy, 4);
        chk("t3_next_head", data_out, 6'h22);
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t3_drained_occ", occupancy, 0);
        chk("t3_drained_q", exp_q.size(), 0);

        // bubbles collapse
        cyc(1'b1, 6'h05, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h06, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_occ", occupancy, 2);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_head", data_out, 6'h05);
        chk("t4_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t4_drained_occ", occupancy, 0);
        chk("t4_drained_q", exp_q.size(), 0);

        // CE stall
        cyc(1'b1, 6'h31, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h32, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        chk("t5_pre_out_valid", out_valid, 1);
        chk("t5_pre_occ", occupancy, 2);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 6'h3f, 1'b0, 1'b0, 1'b0);
            chk("t5_stall_in_ready", in_ready, 0);
            chk("t5_stall_data", data_out, 6'h31);
            chk("t5_stall_occ", occupancy, 2);
        end
        cyc(1'b1, 6'h3f, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 6'h3f, 1'b1, 1'b0, 1'b0);
        chk("t5_stall_out_valid", out_valid, 0);
        chk("t5_stall_occ_dec", occupancy, 1);
        chk("t5_stall_in_ready2", in_ready, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t5_drained_occ", occupancy, 0);
        chk("t5_drained_q", exp_q.size(), 0);

        // flush while full
        cyc(1'b1, 6'h01, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h02, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h03, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h04, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'h15, 1'b1, 1'b1, 1'b1);
        chk("t6_flush_in_ready", in_ready, 0);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_flush_occ", occupancy, 0);
        chk("t6_flush_out_valid", out_valid, 0);
        chk("t6_flush_data", data_out, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t6_flush_no_capture", occupancy, 0);

        // async reset while streaming
        for (int i = 0; i < 6; i++) cyc(1'b1, 6'(6'h0a + i), 1'b1, 1'b1, 1'b0);
        chk("t6_stream_out_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_out_valid", out_valid, 0);
        chk("t6_arst_data", data_out, 0);
        chk("t6_arst_occ", occupancy, 0);
        chk("t6_arst_in_ready", in_ready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #2;
        chk("t6_rel_in_ready", in_ready, 1);
        cyc(1'b1, 6'h2b, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        chk("t6_post_rst_q", exp_q.size(), 0);
        chk("t6_post_rst_occ", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
